usr_ctrl: RTL and testbench
===========================

# usr_ctrl

Transmit sequencer for the universal shift register path. It accepts parallel words on a valid/ready handshake, buffers one word, loads it into an internal WIDTH-bit shift register and clocks it out MSB-first on a serial line. It frames each word, can insert inter-word gap cycles and pulses `done` per word. It sits between a word-producing master and the pin-level serial output.

## Interface
- `WIDTH`, 8: data word width; legal range 2..32.
- `GAP_CYCLES`, 0: idle cycles forced between words; legal range 0..255.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  master presents `s_data`.
- `s_ready`  out  1  holding register empty; word accepted on `s_valid && s_ready` at a rising edge.
- `s_data`  in  WIDTH  parallel word.
- `ser_out`  out  1  serial data, registered.
- `ser_frame`  out  1  high on every cycle `ser_out` carries a data or parity bit.
- `done`  out  1  one-cycle pulse on the last bit cycle of a word.
- `busy`  out  1  state != IDLE or holding register full.

One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- Holding register `hold` plus `hold_full` flag. Handshake writes `hold` and sets `hold_full`. `s_ready = !hold_full`.
- States:
  - IDLE: if `hold_full`, load `hold` into the shift register, clear `hold_full`, set bit count to 0, go to SHIFT.
  - SHIFT: `ser_out` = shift register MSB, `ser_frame=1`; shift left each cycle.
    - On bit count WIDTH-1, go to PARITY if enabled.
    - Otherwise go to GAP if `GAP_CYCLES>0`.
    - Otherwise, if `hold_full`, reload (back-to-back, stay in SHIFT); else go to IDLE.
  - PARITY (macro only): one bit cycle with `ser_frame=1`, then the same exit rule as the last SHIFT cycle.
  - GAP: `ser_frame=0`, `ser_out=0` for exactly `GAP_CYCLES` cycles. On the last GAP cycle, reload and go to SHIFT if `hold_full`; else go to IDLE.
- `done` is high in the final bit cycle: the last data bit, or the parity bit when PARITY is enabled.
- Outside frame cycles, `ser_out` is 0.
- Bit/gap counter width is `$clog2(max(WIDTH, GAP_CYCLES+1))`. No wrap beyond its terminal value.
- A handshake in the same cycle as a reload is legal: `s_ready` was high, `hold` is consumed and rewritten in one edge, and `hold_full` stays 1.

## Timing
- Reset values: `ser_out=0`, `ser_frame=0`, `done=0`, `busy=0`, `s_ready=1`, state IDLE, `hold_full=0`.
- Latency: handshake at the edge ending cycle c gives the first bit on `ser_out` in cycle c+2. The last data bit is in cycle c+WIDTH+1.
- Back-to-back with `GAP_CYCLES=0`: `ser_frame` stays high continuously across words, with no bubble.
- Throughput: one word per WIDTH (+1 with parity) + `GAP_CYCLES` cycles.
- Reset mid-operation: the frame aborts immediately (`ser_frame` low the cycle after `rst` is sampled) and `hold` is discarded.
- `s_data` is sampled only at the handshake edge; later changes have no effect.

## Configuration
- `USR_CTRL_PARITY_EN` defined: the PARITY state is compiled in and appends one even-parity bit (XOR of all WIDTH data bits) after the LSB. `done` moves to the parity cycle.
- Undefined: there is no PARITY state and frames are exactly WIDTH bits.

## Structure
- Package `usr_ctrl_pkg`:
  - state encoding constants (IDLE, SHIFT, PARITY, GAP);
  - counter-width function;
  - parameter range checks.
- Sub-module `usr_bit_counter`: a loadable up-counter with a terminal-count flag. It is shared by SHIFT (terminal WIDTH-1) and GAP (terminal `GAP_CYCLES-1`).
- The shift register and holding register stay inline in `usr_ctrl`.

## Test plan
- WIDTH=8, send 0xA5 -> `ser_out` = 1,0,1,0,0,1,0,1 in cycles c+2..c+9, `ser_frame` high for exactly those 8 cycles, `done` in c+9.
- GAP=0, hold `s_valid` with 0xFF then 0x00 -> `ser_frame` high for 16 consecutive cycles, `ser_out` eight 1s then eight 0s, two `done` pulses 8 cycles apart.
- GAP=3, two words back-to-back -> `ser_frame` low for exactly 3 cycles between the frames.
- `USR_CTRL_PARITY_EN`, send 0x07 -> 8 data bits then parity bit 1, 9-cycle frame, `done` on the 9th cycle. Send 0x03 -> parity bit 0.
- `s_valid` held high while `hold` is full -> `s_ready=0`, no word lost or duplicated, words emitted in order.
- Assert `rst` on the 4th bit of 0xA5 while `hold` is full -> the next cycle has `ser_frame=0`, `busy=0`, `s_ready=1`, and nothing is emitted afterward.

Source files
------------

// File: rtl/usr_ctrl_pkg.sv
// usr_ctrl_pkg: state encodings, counter sizing and parameter legality for usr_ctrl.
package usr_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    // The counter must reach WIDTH-1 (bits) and GAP_CYCLES-1 (gap), so it is
    // sized for the larger of WIDTH and GAP_CYCLES+1.
    function automatic int cnt_width(input int width, input int gap);
        int m;
        m = (width > gap + 1) ? width : gap + 1;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic bit params_ok(input int width, input int gap);
        return (width >= 2) && (width <= 32) && (gap >= 0) && (gap <= 255);
    endfunction

endpackage

// File: rtl/usr_bit_counter.sv
// usr_bit_counter: loadable, saturating up-counter with terminal-count flag.
// Shared between the data-bit phase and the inter-word gap phase.
module usr_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] cnt_next,
    output logic          tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == term);

    // Next count: load to zero wins; otherwise step, holding at the terminal value.
    always_comb begin
        cnt_next = cnt;
        if (load)
            cnt_next = '0;
        else if (en && !tc)
            cnt_next = cnt + CW'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

endmodule

// File: rtl/usr_ctrl.sv
// usr_ctrl: word-to-serial transmit sequencer, MSB first, with optional
// inter-word gap. Optional feature: define USR_CTRL_PARITY_EN to append one
// even-parity bit after each word's LSB.
module usr_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done,
    output logic             busy
);

    if (!params_ok(WIDTH, GAP_CYCLES)) begin : g_bad_params
        $error("usr_ctrl: WIDTH must be 2..32 and GAP_CYCLES 0..255");
    end

    localparam int            CW       = cnt_width(WIDTH, GAP_CYCLES);
    localparam logic [CW-1:0] BIT_TERM = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_TERM = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] sr, sr_n, hold;
    logic             hold_full, accept, consume, fin;
    logic             cnt_load, cnt_en, tc;
    logic [CW-1:0]    cnt_n, term;
    logic             out_n, frame_n, done_n;
`ifdef USR_CTRL_PARITY_EN
    logic             par, par_n;
`endif

    assign s_ready = !hold_full;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE) || hold_full;
    assign term    = (state == ST_GAP) ? GAP_TERM : BIT_TERM;

    usr_bit_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .term     (term),
        .cnt_next (cnt_n),
        .tc       (tc)
    );

    // Sequencer next state; 'fin' applies the common end-of-word exit rule and
    // 'consume' moves the holding word into the shift register.
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        consume  = 1'b0;
        fin      = 1'b0;
`ifdef USR_CTRL_PARITY_EN
        par_n    = par;
`endif
        case (state)
            ST_IDLE: begin
                if (hold_full)
                    consume = 1'b1;
            end
            ST_SHIFT: begin
                sr_n = sr << 1;
                if (tc) begin
`ifdef USR_CTRL_PARITY_EN
                    state_n = ST_PARITY;
`else
                    fin = 1'b1;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
`ifdef USR_CTRL_PARITY_EN
            ST_PARITY: fin = 1'b1;
`endif
            ST_GAP: begin
                if (tc) begin
                    if (hold_full)
                        consume = 1'b1;
                    else
                        state_n = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (fin) begin
            if (GAP_CYCLES > 0) begin
                state_n  = ST_GAP;
                cnt_load = 1'b1;
            end else if (hold_full) begin
                consume = 1'b1;
            end else begin
                state_n = ST_IDLE;
            end
        end

        if (consume) begin
            state_n  = ST_SHIFT;
            sr_n     = hold;
            cnt_load = 1'b1;
`ifdef USR_CTRL_PARITY_EN
            par_n    = ^hold;
`endif
        end
    end

    // Output values for the coming cycle, derived from next state so the pins are registered.
    always_comb begin
        out_n   = 1'b0;
        frame_n = 1'b0;
        done_n  = 1'b0;
        if (state_n == ST_SHIFT) begin
            out_n   = sr_n[WIDTH-1];
            frame_n = 1'b1;
`ifndef USR_CTRL_PARITY_EN
            done_n  = (cnt_n == BIT_TERM);
`endif
        end
`ifdef USR_CTRL_PARITY_EN
        if (state_n == ST_PARITY) begin
            out_n   = par_n;
            frame_n = 1'b1;
            done_n  = 1'b1;
        end
`endif
    end

    // Sequencer state, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sr        <= '0;
            ser_out   <= 1'b0;
            ser_frame <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            ser_out   <= out_n;
            ser_frame <= frame_n;
            done      <= done_n;
        end
    end

`ifdef USR_CTRL_PARITY_EN
    // Parity of the word currently being shifted, captured at load.
    always_ff @(posedge clk) begin
        if (rst)
            par <= 1'b0;
        else
            par <= par_n;
    end
`endif

    // Holding register: a same-edge consume and accept leaves it full with the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept)
                hold <= s_data;
            hold_full <= accept || (hold_full && !consume);
        end
    end

endmodule

// File: tb/tb_usr_ctrl.sv
// tb_usr_ctrl: two usr_ctrl instances (GAP_CYCLES 0 and 3) checked by a
// directed vector table, hand sequences and a randomized run against a
// per-cycle output-stream reference model.
module tb_usr_ctrl;

    localparam int W  = 8;
    localparam int G0 = 0;
    localparam int G1 = 3;
`ifdef USR_CTRL_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = W + PB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     s_valid = 2'b00;
    logic [W-1:0]   s_data [2];
    logic [1:0]     s_ready, ser_out, ser_frame, done, busy;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    usr_ctrl #(.WIDTH(W), .GAP_CYCLES(G0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .ser_out(ser_out[0]), .ser_frame(ser_frame[0]), .done(done[0]), .busy(busy[0]));

    usr_ctrl #(.WIDTH(W), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .ser_out(ser_out[1]), .ser_frame(ser_frame[1]), .done(done[1]), .busy(busy[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance owns a stream of {ser_out, ser_frame, done} slots, front =
    // current cycle. A waiting word enters the stream when nothing is scheduled
    // after the current cycle; a word contributes its bits, optional parity and gap slots.
    logic [2:0]   rb [2][64];
    int           rh [2];
    int           rn [2];
    logic         mfull [2];
    logic [W-1:0] mhold [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    task automatic put(input int i, input logic [2:0] v);
        rb[i][(rh[i] + rn[i]) % 64] = v;
        rn[i]++;
    endtask

    task automatic append_word(input int i, input logic [W-1:0] d);
        int ones;
        ones = 0;
        for (int b = W - 1; b >= 0; b--) begin
            ones += int'(d[b]);
            put(i, {d[b], 1'b1, (b == 0) && (PB == 0)});
        end
        if (PB == 1) put(i, {ones % 2 == 1, 1'b1, 1'b1});
        for (int g = 0; g < gap_of(i); g++) put(i, 3'b000);
    endtask

    task automatic model_step(input int i);
        logic consume, accept;
        if (rst) begin
            rh[i] = 0; rn[i] = 0; mfull[i] = 1'b0;
            return;
        end
        if (rn[i] > 0) begin
            rh[i] = (rh[i] + 1) % 64;
            rn[i]--;
        end
        consume = mfull[i] && (rn[i] == 0);
        if (consume) append_word(i, mhold[i]);
        accept = s_valid[i] && !mfull[i];
        if (accept) mhold[i] = s_data[i];
        mfull[i] = accept || (mfull[i] && !consume);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int i = 0; i < 2; i++) begin
                logic [2:0] e;
                e = (rn[i] > 0) ? rb[i][rh[i]] : 3'b000;
                chk($sformatf("mon%0d", i),
                    {27'd0, ser_out[i], ser_frame[i], done[i], s_ready[i], busy[i]},
                    {27'd0, e, !mfull[i], (rn[i] > 0) || mfull[i]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call at a negedge; returns at the negedge after the handshake edge.
    task automatic push(input int i, input logic [W-1:0] d);
        int n;
        n = 0;
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        while (!s_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL push_timeout: s_ready stayed 0 on dut%0d", i);
        end
        @(posedge clk);
        @(negedge clk);
        s_valid[i] = 1'b0;
    endtask

    logic [2:0] rec [64];

    task automatic record(input int i, input int n);
        for (int k = 0; k < 64; k++) rec[k] = 3'b000;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rec[k] = {ser_out[i], ser_frame[i], done[i]};
        end
    endtask

    task automatic runs(output int s, output int r1, output int g, output int r2);
        int k;
        k = 0;
        while (k < 64 && !rec[k][1]) k++;
        s = k;
        r1 = 0; while (k < 64 &&  rec[k][1]) begin r1++; k++; end
        g  = 0; while (k < 64 && !rec[k][1]) begin g++;  k++; end
        r2 = 0; while (k < 64 &&  rec[k][1]) begin r2++; k++; end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] bits;   // expected ser_out sequence, first bit at the MSB
        logic         par;
    } vec_t;

    vec_t tbl [6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r1, g, r2, nd, d1, d2, bad;

        tbl[0] = '{8'hA5, 8'b1010_0101, 1'b0};
        tbl[1] = '{8'hFF, 8'b1111_1111, 1'b0};
        tbl[2] = '{8'h00, 8'b0000_0000, 1'b0};
        tbl[3] = '{8'h07, 8'b0000_0111, 1'b1};
        tbl[4] = '{8'h03, 8'b0000_0011, 1'b0};
        tbl[5] = '{8'h80, 8'b1000_0000, 1'b1};

        s_data[0] = '0;
        s_data[1] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_state%0d", i),
                {ser_out[i], ser_frame[i], done[i], s_ready[i], busy[i]}, 5'b00010);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Vector table on dut0: latency, bit order, frame length, done placement.
        for (int t = 0; t < 6; t++) begin
            push(0, tbl[t].data);
            chk("tbl_latency", ser_frame[0], 1'b0);
            for (int k = 0; k < W; k++) begin
                @(negedge clk);
                chk($sformatf("tbl%0d_bit%0d", t, k), {ser_out[0], ser_frame[0], done[0]},
                    {tbl[t].bits[W-1-k], 1'b1, (k == W - 1) && (PB == 0)});
            end
            if (PB == 1) begin
                @(negedge clk);
                chk($sformatf("tbl%0d_par", t), {ser_out[0], ser_frame[0], done[0]},
                    {tbl[t].par, 1'b1, 1'b1});
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_end", t), {ser_out[0], ser_frame[0], done[0]}, 3'b000);
            repeat (2) @(negedge clk);
        end

        // Back-to-back 0xFF, 0x00 with no gap: one unbroken frame of two words.
        fork
            begin push(0, 8'hFF); push(0, 8'h00); end
            record(0, 50);
        join
        runs(s, r1, g, r2);
        chk("b2b_frame_len", r1, 2 * FL);
        nd = 0; d1 = -1; d2 = -1; bad = 0;
        for (int k = 0; k < 64; k++) if (rec[k][0]) begin
            nd++;
            if (d1 < 0) d1 = k - s; else d2 = k - s;
        end
        chk("b2b_done_count", nd, 2);
        chk("b2b_done_pos", {d1[15:0], d2[15:0]}, {16'(FL - 1), 16'(2 * FL - 1)});
        for (int j = 0; j < 2 * FL; j++)
            if ((j % FL) < W && rec[s + j][2] !== (j < FL)) bad++;
        chk("b2b_data", bad, 0);
        repeat (4) @(negedge clk);

        // Two words back-to-back on the GAP_CYCLES=3 instance.
        fork
            begin push(1, 8'h5A); push(1, 8'hC3); end
            record(1, 50);
        join
        runs(s, r1, g, r2);
        chk("gap_frame1", r1, FL);
        chk("gap_len", g, G1);
        chk("gap_frame2", r2, FL);
        repeat (4) @(negedge clk);

        // Reset on the 4th bit of 0xA5 with a second word waiting.
        push(0, 8'hA5);          // now in cycle c+1
        push(0, 8'h3C);          // accepted at end of c+2, now in c+3
        @(negedge clk);          // c+4
        @(negedge clk);          // c+5: 4th bit
        chk("rst_pre", {ser_frame[0], s_ready[0], busy[0]}, 3'b101);
        rst = 1'b1;
        @(negedge clk);          // c+6
        chk("rst_abort", {ser_out[0], ser_frame[0], done[0], s_ready[0], busy[0]}, 5'b00010);
        rst = 1'b0;
        record(0, 20);
        nd = 0;
        for (int k = 0; k < 20; k++) if (rec[k][1] || rec[k][0]) nd++;
        chk("rst_silent", nd, 0);

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                s_valid[i] = ($urandom_range(0, 3) != 0);
                s_data[i]  = W'($urandom);
            end
            @(negedge clk);
        end
        s_valid = 2'b00;
        repeat (60) @(negedge clk);
        chk("drain_idle", {busy, ser_frame}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
